// File: rtl/bus_coherence_ctrl.sv
// rtl/bus_coherence_ctrl.sv - two-core snooping coherence controller in front of a single-port RAM
// One transaction per grant: word write, or two-word block read with snoop and optional dirty forward.
module bus_coherence_ctrl #(
  parameter int CORES = 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [CORES-1:0]            dREN,
  input  logic [CORES-1:0]            dWEN,
  input  logic [CORES-1:0][31:0]      daddr,
  input  logic [CORES-1:0][31:0]      dstore,
  input  logic [CORES-1:0]            ccwrite,
  input  logic [CORES-1:0]            cctrans,
  output logic [CORES-1:0]            dwait,
  output logic [CORES-1:0][31:0]      dload,
  output logic [CORES-1:0]            ccwait,
  output logic [CORES-1:0]            ccinv,
  output logic [CORES-1:0][31:0]      ccsnoopaddr,
  output logic                        ramREN,
  output logic                        ramWEN,
  output logic [31:0]                 ramaddr,
  output logic [31:0]                 ramstore,
  input  logic [31:0]                 ramload,
  input  logic [1:0]                  ramstate
);

  typedef enum logic [2:0] {
    IDLE, WRITE, SNOOP, FWD0, FWD1, LOAD0, LOAD1
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t     state_q, state_d;
  logic       req_q, req_d;
  logic       last_q, last_d;
  logic       snp;
  logic       access;
  logic       grant;
  logic [CORES-1:0] cand;

  assign snp    = ~req_q;
  // BUSY, FREE and ERROR all just hold; only ACCESS completes a word.
  assign access = (ramstate == RAM_ACCESS);

  // Writes outrank reads; a tie goes to the core not granted last time.
  assign cand  = (|dWEN) ? dWEN : dREN;
  assign grant = (cand == 2'b11) ? ~last_q : cand[1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    last_d      = last_q;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          req_d   = grant;
          last_d  = grant;
          state_d = (|dWEN) ? WRITE : SNOOP;
        end
      end
      WRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req_q];
        ramstore = dstore[req_q];
        if (access) begin
          dwait[req_q] = 1'b0;
          state_d      = IDLE;
        end
      end
      SNOOP: begin
        ccwait[snp]      = 1'b1;
        ccsnoopaddr[snp] = daddr[req_q];
        ccinv[snp]       = ccwrite[req_q];
        if (cctrans[snp]) begin
          state_d = ccwrite[snp] ? FWD0 : LOAD0;
        end
      end
      FWD0, FWD1: begin
        // Dirty line: the owner writes back while the requester snarfs the same data.
        ccwait[snp]  = 1'b1;
        ramWEN       = 1'b1;
        ramaddr      = daddr[snp];
        ramstore     = dstore[snp];
        dload[req_q] = dstore[snp];
        if (access) begin
          dwait   = '0;
          state_d = (state_q == FWD0) ? FWD1 : IDLE;
        end
      end
      LOAD0, LOAD1: begin
        ramREN       = 1'b1;
        ramaddr      = daddr[req_q];
        dload[req_q] = ramload;
        if (access) begin
          dwait[req_q] = 1'b0;
          state_d      = (state_q == LOAD0) ? LOAD1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
